// File: rtl/key_entry_buffer.sv
// key_entry_buffer: N-digit BCD entry buffer with shift/overwrite editing, commit/cancel, preset load, cursor blink and idle timeout
//   clk, reset            : clock, synchronous active-high reset
//   key_code, key_valid   : decoded key event (0-9 digit, A left, B right, C backspace, D mode, E cancel, F commit)
//   load_valid, load_value: external preset of the committed value
//   digits, cursor        : working value and cursor index for the display
//   blink_mask            : digits to blank right now (cursor blink in overwrite edit)
//   editing, mode         : edit-state flag and current edit mode (0 shift, 1 overwrite)
//   commit_valid          : one-cycle strobe when a commit happens
//   commit_value          : committed value
module key_entry_buffer #(
    parameter int N_DIGITS       = 6,
    parameter int CW             = 3,
    parameter int BLINK_CYCLES   = 50_000_000,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int MODE_INIT      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            key_code,
    input  logic                  key_valid,
    input  logic                  load_valid,
    input  logic [4*N_DIGITS-1:0] load_value,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [CW-1:0]         cursor,
    output logic [N_DIGITS-1:0]   blink_mask,
    output logic                  editing,
    output logic                  mode,
    output logic                  commit_valid,
    output logic [4*N_DIGITS-1:0] commit_value
);
    localparam int W  = 4 * N_DIGITS;
    localparam int BW = $clog2(BLINK_CYCLES);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);

    typedef enum logic {IDLE, EDIT} state_t;

    state_t        state;
    logic [BW-1:0] bcnt;
    logic          phase;
    logic [TW-1:0] tcnt;
    logic          is_digit;
    logic          bwrap;
    logic          timeout;
    logic [CW-1:0] cur_left;
    logic [CW-1:0] cur_right;

    assign is_digit  = key_valid && key_code <= 4'd9;
    assign bwrap     = bcnt == BW'(BLINK_CYCLES - 1);
    // tcnt holds the idle cycles already counted, so the edge completing the last one cancels
    assign timeout   = TIMEOUT_CYCLES != 0 && state == EDIT && !key_valid && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign cur_left  = cursor == LAST ? '0 : cursor + 1'b1;
    assign cur_right = cursor == '0 ? LAST : cursor - 1'b1;
    assign editing   = state == EDIT;
    assign blink_mask = (editing && mode && phase) ? N_DIGITS'(1) << cursor : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            digits       <= '0;
            commit_value <= '0;
            cursor       <= LAST;
            mode         <= 1'(MODE_INIT);
            commit_valid <= 1'b0;
            bcnt         <= '0;
            phase        <= 1'b0;
            tcnt         <= '0;
        end else begin
            commit_valid <= 1'b0;
            bcnt  <= (key_valid || bwrap) ? '0 : bcnt + 1'b1;
            phase <= key_valid ? 1'b0 : phase ^ bwrap;
            tcnt  <= (state == IDLE || key_valid) ? '0 : tcnt + 1'b1;
            if (state == IDLE) begin
                // a digit key starting an edit takes priority over a simultaneous preset
                if (load_valid && !is_digit) begin
                    commit_value <= load_value;
                    digits       <= load_value;
                end
                if (is_digit) begin
                    state <= EDIT;
                    if (mode) begin
                        digits[{LAST, 2'b00} +: 4] <= key_code;
                        cursor <= LAST - 1'b1;
                    end else
                        digits <= {{(W-4){1'b0}}, key_code};
                end else if (key_valid && key_code == 4'hD) begin
                    state  <= EDIT;
                    mode   <= ~mode;
                    cursor <= LAST;
                end
            end else if (key_valid && key_code == 4'hF) begin
                commit_value <= digits;
                commit_valid <= 1'b1;
                state        <= IDLE;
            end else if (timeout || (key_valid && key_code == 4'hE)) begin
                commit_value <= load_valid ? load_value : commit_value;
                digits       <= load_valid ? load_value : commit_value;
                state        <= IDLE;
            end else begin
                if (load_valid)
                    commit_value <= load_value;
                if (is_digit && !mode)
                    digits <= {digits[W-5:0], key_code};
                else if (is_digit) begin
                    digits[{cursor, 2'b00} +: 4] <= key_code;
                    cursor <= cur_right;
                end else if (key_valid && key_code == 4'hC) begin
                    if (mode)
                        digits[{cursor, 2'b00} +: 4] <= 4'h0;
                    else
                        digits <= {4'h0, digits[W-1:4]};
                end else if (key_valid && key_code == 4'hA && mode)
                    cursor <= cur_left;
                else if (key_valid && key_code == 4'hB && mode)
                    cursor <= cur_right;
                else if (key_valid && key_code == 4'hD) begin
                    mode   <= ~mode;
                    cursor <= LAST;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_entry_buffer.sv
// tb_key_entry_buffer: directed stimulus checked every cycle against a digit-array model plus literal expectations
module tb_key_entry_buffer;
    localparam int N  = 6;
    localparam int CW = 3;
    localparam int BC = 4;
    localparam int TC = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [3:0]     key_code = '0;
    logic           key_valid = 1'b0;
    logic           load_valid = 1'b0;
    logic [4*N-1:0] load_value = '0;
    logic [4*N-1:0] digits;
    logic [CW-1:0]  cursor;
    logic [N-1:0]   blink_mask;
    logic           editing;
    logic           mode;
    logic           commit_valid;
    logic [4*N-1:0] commit_value;

    int errors = 0;
    int checks = 0;

    key_entry_buffer #(
        .N_DIGITS(N), .CW(CW), .BLINK_CYCLES(BC), .TIMEOUT_CYCLES(TC), .MODE_INIT(0)
    ) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .load_valid(load_valid), .load_value(load_value), .digits(digits),
        .cursor(cursor), .blink_mask(blink_mask), .editing(editing), .mode(mode),
        .commit_valid(commit_valid), .commit_value(commit_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: digits as an array, phase and timeout both derived from cycles since the last key
    int mw[N];
    int mc[N];
    int mcur;
    bit medit;
    bit mmode;
    bit mcv;
    int since;

    function automatic logic [4*N-1:0] pack_w();
        logic [4*N-1:0] r;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(mw[i]);
        return r;
    endfunction

    function automatic logic [4*N-1:0] pack_c();
        logic [4*N-1:0] r;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(mc[i]);
        return r;
    endfunction

    always @(posedge clk) begin
        bit dig;
        bit tmo;
        mcv = 1'b0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin mw[i] = 0; mc[i] = 0; end
            mcur = N - 1; medit = 1'b0; mmode = 1'b0; since = 0;
        end else begin
            dig = key_valid && key_code <= 4'd9;
            since = key_valid ? 0 : since + 1;
            tmo = medit && !key_valid && since == TC;
            if (!medit) begin
                if (load_valid && !dig)
                    for (int i = 0; i < N; i++) begin mc[i] = int'(load_value[4*i +: 4]); mw[i] = mc[i]; end
                if (dig) begin
                    medit = 1'b1;
                    if (!mmode) begin
                        for (int i = 0; i < N; i++) mw[i] = 0;
                        mw[0] = int'(key_code);
                    end else begin
                        mw[N-1] = int'(key_code);
                        mcur = N - 2;
                    end
                end else if (key_valid && key_code == 4'hD) begin
                    mmode = !mmode; medit = 1'b1; mcur = N - 1;
                end
            end else if (key_valid && key_code == 4'hF) begin
                for (int i = 0; i < N; i++) mc[i] = mw[i];
                mcv = 1'b1; medit = 1'b0;
            end else begin
                if (load_valid)
                    for (int i = 0; i < N; i++) mc[i] = int'(load_value[4*i +: 4]);
                if (tmo || (key_valid && key_code == 4'hE)) begin
                    for (int i = 0; i < N; i++) mw[i] = mc[i];
                    medit = 1'b0;
                end else if (key_valid) begin
                    if (dig && !mmode) begin
                        for (int i = N - 1; i > 0; i--) mw[i] = mw[i-1];
                        mw[0] = int'(key_code);
                    end else if (dig) begin
                        mw[mcur] = int'(key_code);
                        mcur = (mcur + N - 1) % N;
                    end else if (key_code == 4'hC && !mmode) begin
                        for (int i = 0; i < N - 1; i++) mw[i] = mw[i+1];
                        mw[N-1] = 0;
                    end else if (key_code == 4'hC)
                        mw[mcur] = 0;
                    else if (key_code == 4'hA && mmode)
                        mcur = (mcur + 1) % N;
                    else if (key_code == 4'hB && mmode)
                        mcur = (mcur + N - 1) % N;
                    else if (key_code == 4'hD) begin
                        mmode = !mmode; mcur = N - 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] one;
        logic [N-1:0] em;
        one = 1;
        em = (medit && mmode && ((since / BC) % 2 == 1)) ? one << mcur : '0;
        chk("digits", 32'(digits), 32'(pack_w()));
        chk("commit_value", 32'(commit_value), 32'(pack_c()));
        chk("cursor", 32'(cursor), 32'(mcur));
        chk("editing", 32'(editing), 32'(medit));
        chk("mode", 32'(mode), 32'(mmode));
        chk("commit_valid", 32'(commit_valid), 32'(mcv));
        chk("blink_mask", 32'(blink_mask), 32'(em));
    end

    task automatic drive(input bit kv, input logic [3:0] k, input bit lv, input logic [4*N-1:0] v);
        key_valid = kv; key_code = k; load_valid = lv; load_value = v;
        @(posedge clk); #1;
        key_valid = 1'b0; load_valid = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        drive(1'b1, k, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [3:0] seq [16] = '{4'hD, 4'h4, 4'hB, 4'hC, 4'h6, 4'hA, 4'hA, 4'hA,
                              4'h7, 4'hC, 4'hD, 4'h8, 4'hC, 4'h9, 4'hF, 4'hA};

    initial begin
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("lit_rst_digits", 32'(digits), 32'h0);
        chk("lit_rst_cursor", 32'(cursor), 32'd5);
        chk("lit_rst_editing", 32'(editing), 32'd0);

        key(4'h1); key(4'h2); key(4'h3); key(4'hF);
        chk("lit_commit_digits", 32'(digits), 32'h000123);
        chk("lit_commit_valid", 32'(commit_valid), 32'd1);
        chk("lit_commit_value", 32'(commit_value), 32'h000123);
        chk("lit_commit_editing", 32'(editing), 32'd0);
        idle(1);
        chk("lit_commit_pulse_end", 32'(commit_valid), 32'd0);

        for (int i = 1; i <= 7; i++) key(4'(i));
        chk("lit_shift_drop", 32'(digits), 32'h234567);
        key(4'hC);
        chk("lit_backspace", 32'(digits), 32'h023456);
        key(4'hE);
        chk("lit_cancel", 32'(digits), 32'h000123);
        chk("lit_cancel_editing", 32'(editing), 32'd0);

        key(4'hD);
        chk("lit_ow_cursor", 32'(cursor), 32'd5);
        chk("lit_ow_mode", 32'(mode), 32'd1);
        key(4'h9);
        chk("lit_ow_write", 32'(digits), 32'h900123);
        chk("lit_ow_cursor_move", 32'(cursor), 32'd4);
        repeat (6) key(4'hB);
        chk("lit_right_wrap", 32'(cursor), 32'd4);
        key(4'hA);
        key(4'hA);
        chk("lit_left_wrap", 32'(cursor), 32'd0);

        repeat (3) key(4'hA);
        idle(3);
        chk("lit_blink_off", 32'(blink_mask), 32'h00);
        idle(1);
        chk("lit_blink_on", 32'(blink_mask), 32'h08);
        idle(4);
        chk("lit_blink_off2", 32'(blink_mask), 32'h00);
        idle(1);
        key(4'hB);
        idle(3);
        chk("lit_key_forces_off", 32'(blink_mask), 32'h00);

        key(4'hD);
        key(4'h5);
        idle(9);
        chk("lit_before_timeout", 32'(editing), 32'd1);
        idle(1);
        chk("lit_timeout_editing", 32'(editing), 32'd0);
        chk("lit_timeout_digits", 32'(digits), 32'h000123);

        drive(1'b0, 4'h0, 1'b1, 24'h654321);
        chk("lit_load_idle", 32'(digits), 32'h654321);
        key(4'h1);
        drive(1'b0, 4'h0, 1'b1, 24'h111111);
        chk("lit_load_edit_commit", 32'(commit_value), 32'h111111);
        chk("lit_load_edit_digits", 32'(digits), 32'h000001);
        key(4'h2);
        drive(1'b1, 4'hF, 1'b1, 24'h999999);
        chk("lit_commit_beats_load", 32'(commit_value), 32'h000012);
        chk("lit_commit_load_valid", 32'(commit_valid), 32'd1);
        drive(1'b1, 4'h3, 1'b1, 24'h888888);
        chk("lit_digit_beats_load", 32'(digits), 32'h000003);
        drive(1'b1, 4'hE, 1'b1, 24'h444444);
        chk("lit_cancel_load", 32'(digits), 32'h444444);

        foreach (seq[i]) begin key(seq[i]); idle(1); end

        key(4'h7);
        reset = 1'b1;
        drive(1'b1, 4'hF, 1'b1, 24'h777777);
        reset = 1'b0;
        chk("lit_rst_key_digits", 32'(digits), 32'h0);
        chk("lit_rst_key_commit", 32'(commit_value), 32'h0);
        chk("lit_rst_key_cv", 32'(commit_valid), 32'd0);
        chk("lit_rst_key_cursor", 32'(cursor), 32'd5);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
